cpu_seq_ctrl: RTL and testbench

Multi-cycle control unit for the RISC CPU datapath. It fetches each instruction over a ready/valid memory handshake and latches it. It then decodes the 6-bit opcode and sequences execute, memory and writeback, driving operand-B source select, register write, memory strobes and PC advance. It replaces per-block opcode decoding with one sequencer that owns all datapath control.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_op_decode.sv | 34 +++
 rtl/cpu_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and select constants for the sequencer
package cpu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd2;
    localparam logic [OP_W-1:0] OP_STORE = 6'd3;
    localparam logic [OP_W-1:0] OP_LOAD  = 6'd4;
    localparam logic [OP_W-1:0] OP_MOVE  = 6'd5;
    localparam logic [OP_W-1:0] OP_SGE   = 6'd6;
    localparam logic [OP_W-1:0] OP_SLE   = 6'd7;
    localparam logic [OP_W-1:0] OP_SGT   = 6'd8;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd9;
    localparam logic [OP_W-1:0] OP_SEQ   = 6'd10;
    localparam logic [OP_W-1:0] OP_SNE   = 6'd11;
    localparam logic [OP_W-1:0] OP_AND   = 6'd12;
    localparam logic [OP_W-1:0] OP_OR    = 6'd13;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd14;
    localparam logic [OP_W-1:0] OP_NOT   = 6'd15;
    localparam logic [OP_W-1:0] OP_MOVEI = 6'd16;
    localparam logic [OP_W-1:0] OP_SLI   = 6'd17;
    localparam logic [OP_W-1:0] OP_SRI   = 6'd18;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'd20;

    localparam logic OPB_REG = 1'b0;
    localparam logic OPB_IMM = 1'b1;
    localparam logic WB_ALU  = 1'b0;
    localparam logic WB_MEM  = 1'b1;

    typedef enum logic [5:0] {
        S_FETCH  = 6'b000001,
        S_DECODE = 6'b000010,
        S_EXEC   = 6'b000100,
        S_MEM    = 6'b001000,
        S_WB     = 6'b010000,
        S_TRAP   = 6'b100000
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_U,
        CLS_ILL
    } op_class_e;

endpackage

// File: rtl/cpu_op_decode.sv
// rtl/cpu_op_decode.sv - combinational opcode classifier
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output op_class_e       cls,
    output logic            is_load,
    output logic            is_store,
    output logic            is_nop,
    output logic            illegal,
    output logic            opb_sel
);

    // Classify the opcode; anything past SUBI is illegal
    always_comb begin
        cls      = CLS_ILL;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_nop   = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_NOP:   begin cls = CLS_NONE; is_nop = 1'b1; end
            OP_STORE: begin cls = CLS_I; is_store = 1'b1; end
            OP_LOAD:  begin cls = CLS_I; is_load = 1'b1; end
            OP_MOVE, OP_NOT: cls = CLS_U;
            OP_MOVEI, OP_SLI, OP_SRI, OP_ADDI, OP_SUBI: cls = CLS_I;
            OP_ADD, OP_SUB, OP_SGE, OP_SLE, OP_SGT, OP_SLT,
            OP_SEQ, OP_SNE, OP_AND, OP_OR, OP_XOR: cls = CLS_R;
            default:  illegal = 1'b1;
        endcase
        opb_sel = (cls == CLS_I) ? OPB_IMM : OPB_REG;
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW          = OP_W,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    instr_rdata,
    output logic           imem_req,
    input  logic           imem_ready,
    input  logic           dmem_ready,
    output logic [31:0]    ir,
    output logic           opb_sel,
    output logic [OPW-1:0] alu_op,
    output logic           reg_we,
    output logic           wb_sel,
    output logic           dmem_re,
    output logic           dmem_we,
    output logic           pc_en,
    output logic           trap,
    output logic [31:0]    instret
);

    state_e          r_state;
    state_e          w_next;
    logic [31:0]     r_ir;
    logic [OPW-1:0]  r_alu_op;
    logic [31:0]     r_instret;

    op_class_e       w_cls;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_nop;
    logic            w_illegal;
    logic            w_opb_sel;
    logic            w_retire_nop;
    logic            w_to_trap;
    logic            w_unused_cls;

    // Decode works on the latched opcode, so outputs never see instr_rdata directly
    cpu_op_decode u_decode (
        .op       (r_alu_op),
        .cls      (w_cls),
        .is_load  (w_is_load),
        .is_store (w_is_store),
        .is_nop   (w_is_nop),
        .illegal  (w_illegal),
        .opb_sel  (w_opb_sel)
    );

    assign w_unused_cls = ^w_cls;
    assign w_to_trap    = w_illegal && ILLEGAL_TRAP;
    assign w_retire_nop = w_is_nop || (w_illegal && !ILLEGAL_TRAP);

    assign ir      = r_ir;
    assign alu_op  = r_alu_op;
    assign instret = r_instret;

    // Next-state and control strobes; reset forces every strobe low in its own cycle
    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        opb_sel  = OPB_REG;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        pc_en    = 1'b0;
        trap     = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                opb_sel = w_opb_sel;
                if (w_to_trap) begin
                    w_next = S_TRAP;
                end else if (w_retire_nop) begin
                    pc_en  = 1'b1;
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                opb_sel = w_opb_sel;
                w_next  = (w_is_load || w_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                opb_sel = w_opb_sel;
                dmem_re = w_is_load;
                dmem_we = w_is_store;
                if (dmem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WB;
                    end else begin
                        pc_en  = 1'b1;
                        w_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                opb_sel = w_opb_sel;
                reg_we  = 1'b1;
                pc_en   = 1'b1;
                wb_sel  = w_is_load ? WB_MEM : WB_ALU;
                w_next  = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (reset) begin
            w_next   = S_FETCH;
            imem_req = 1'b0;
            opb_sel  = OPB_REG;
            reg_we   = 1'b0;
            wb_sel   = WB_ALU;
            dmem_re  = 1'b0;
            dmem_we  = 1'b0;
            pc_en    = 1'b0;
            trap     = 1'b0;
        end
    end

    // State, instruction latch and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_alu_op  <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ready) begin
                r_ir     <= instr_rdata;
                r_alu_op <= instr_rdata[31 -: OPW];
            end
            if (pc_en) r_instret <= r_instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - scoreboard bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;

    localparam logic [7:0] C_REQ  = 8'h80;
    localparam logic [7:0] C_OPB  = 8'h40;
    localparam logic [7:0] C_RWE  = 8'h20;
    localparam logic [7:0] C_WBS  = 8'h10;
    localparam logic [7:0] C_RE   = 8'h08;
    localparam logic [7:0] C_WE   = 8'h04;
    localparam logic [7:0] C_PC   = 8'h02;
    localparam logic [7:0] C_TRAP = 8'h01;

    typedef struct {
        string       tag;
        logic        rst;
        logic        irdy;
        logic        drdy;
        logic [31:0] idata;
        logic [7:0]  ctl;
        logic [31:0] ir;
        logic [31:0] instret;
    } step_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr_rdata;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_ready;
    logic [31:0] ir;
    logic        opb_sel;
    logic [5:0]  alu_op;
    logic        reg_we;
    logic        wb_sel;
    logic        dmem_re;
    logic        dmem_we;
    logic        pc_en;
    logic        trap;
    logic [31:0] instret;

    step_t       q[$];
    logic [31:0] m_ir;
    logic [31:0] m_instret;
    int          checks;
    int          errors;

    cpu_seq_ctrl #(.OPW(6), .ILLEGAL_TRAP(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_rdata (instr_rdata),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .ir          (ir),
        .opb_sel     (opb_sel),
        .alu_op      (alu_op),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .dmem_re     (dmem_re),
        .dmem_we     (dmem_we),
        .pc_en       (pc_en),
        .trap        (trap),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit op_imm(input logic [5:0] op);
        return (op == 6'd3) || (op == 6'd4) || (op >= 6'd16 && op <= 6'd20);
    endfunction

    task automatic push(input string tag, input logic rst, input logic irdy,
                        input logic drdy, input logic [31:0] idata, input logic [7:0] ctl);
        step_t s;
        s.tag = tag; s.rst = rst; s.irdy = irdy; s.drdy = drdy; s.idata = idata;
        s.ctl = ctl; s.ir = m_ir; s.instret = m_instret;
        q.push_back(s);
    endtask

    task automatic gen_reset();
        push("reset", 1'b1, 1'b1, 1'b1, $urandom, 8'h00);
        m_ir = '0;
        m_instret = '0;
    endtask

    // Expected cycle-by-cycle control for one instruction with the given wait states
    task automatic gen_instr(input logic [31:0] instr, input int iw, input int dw);
        logic [5:0] op;
        logic [7:0] b;
        op = instr[31:26];
        for (int k = 0; k <= iw; k++)
            push("fetch", 1'b0, k == iw, 1'b1, (k == iw) ? instr : $urandom, C_REQ);
        m_ir = instr;
        b = op_imm(op) ? C_OPB : 8'h00;
        if (op == 6'd0) begin
            push("nop_decode", 1'b0, 1'b1, 1'b1, $urandom, C_PC);
            m_instret++;
            return;
        end
        if (op > 6'd20) begin
            push("ill_decode", 1'b0, 1'b1, 1'b1, $urandom, 8'h00);
            for (int k = 0; k < 20; k++)
                push("trap", 1'b0, 1'b1, 1'b1, $urandom, C_TRAP);
            return;
        end
        push("decode", 1'b0, 1'b1, 1'b1, $urandom, b);
        push("exec", 1'b0, 1'b1, 1'b1, $urandom, b);
        if (op == 6'd3 || op == 6'd4) begin
            for (int k = 0; k <= dw; k++)
                push("mem", 1'b0, 1'b1, k == dw, $urandom,
                     b | ((op == 6'd4) ? C_RE : C_WE) | ((op == 6'd3 && k == dw) ? C_PC : 8'h00));
            if (op == 6'd3) begin
                m_instret++;
                return;
            end
        end
        push("wb", 1'b0, 1'b1, 1'b1, $urandom,
             b | C_RWE | C_PC | ((op == 6'd4) ? C_WBS : 8'h00));
        m_instret++;
    endtask

    // Drive each queued step after the falling edge and compare outputs 1ns later
    task automatic run();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            reset       = s.rst;
            imem_ready  = s.irdy;
            dmem_ready  = s.drdy;
            instr_rdata = s.idata;
            #1;
            checks++;
            assert ({imem_req, opb_sel, reg_we, wb_sel, dmem_re, dmem_we, pc_en, trap} === s.ctl)
            else begin
                errors++;
                $error("FAIL %s ctl got=%b want=%b", s.tag,
                       {imem_req, opb_sel, reg_we, wb_sel, dmem_re, dmem_we, pc_en, trap}, s.ctl);
            end
            checks++;
            assert (ir === s.ir)
            else begin errors++; $error("FAIL %s ir got=%h want=%h", s.tag, ir, s.ir); end
            checks++;
            assert (alu_op === s.ir[31:26])
            else begin errors++; $error("FAIL %s alu_op got=%0d want=%0d", s.tag, alu_op, s.ir[31:26]); end
            checks++;
            assert (instret === s.instret)
            else begin errors++; $error("FAIL %s instret got=%0d want=%0d", s.tag, instret, s.instret); end
            checks++;
            assert (!(reg_we && dmem_we))
            else begin errors++; $error("FAIL %s we_excl got=1 want=0", s.tag); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_ir = '0; m_instret = '0;
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; instr_rdata = '0;
        repeat (2) @(negedge clk);

        gen_reset();
        run();

        gen_instr(32'h0400_0000 | 32'h0022_1800, 0, 0);
        gen_instr({6'd19, 26'h0123456}, 3, 0);
        gen_instr({6'd4, 26'h0001234}, 0, 2);
        gen_instr({6'd3, 26'h0004321}, 0, 0);
        gen_instr(32'h0000_0000, 0, 0);
        run();

        gen_instr({6'd2, 26'h1555555}, 1, 0);
        gen_instr({6'd5, 26'h0aaaaaa}, 0, 0);
        gen_instr({6'd15, 26'h0000001}, 2, 0);
        gen_instr({6'd9, 26'h3ffffff}, 0, 0);
        gen_instr({6'd14, 26'h0f0f0f0}, 0, 0);
        gen_instr({6'd18, 26'h0000042}, 1, 0);
        gen_instr({6'd20, 26'h0000042}, 0, 0);
        gen_instr({6'd3, 26'h0000777}, 2, 1);
        gen_instr(32'h0000_0000, 2, 0);
        run();

        push("fetch", 1'b0, 1'b1, 1'b1, {6'd4, 26'h0000abc}, C_REQ);
        m_ir = {6'd4, 26'h0000abc};
        push("decode", 1'b0, 1'b1, 1'b1, $urandom, C_OPB);
        push("exec", 1'b0, 1'b1, 1'b1, $urandom, C_OPB);
        push("mem", 1'b0, 1'b1, 1'b0, $urandom, C_OPB | C_RE);
        gen_reset();
        gen_instr({6'd1, 26'h0000005}, 0, 0);
        run();

        gen_instr({6'd63, 26'h0000000}, 0, 0);
        gen_reset();
        gen_instr({6'd12, 26'h0000003}, 0, 0);
        run();

        gen_instr({6'd21, 26'h0000000}, 1, 0);
        gen_reset();
        gen_instr({6'd17, 26'h0000009}, 0, 0);
        run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
